// File: rtl/scsi_initiator_if.sv
// SCSI bus between the host initiator and the CD target. The master side drives
// selection, acknowledge, bus reset and the out data byte.
interface scsi_initiator_if;
    logic [7:0] DB_I;
    logic [7:0] DB_O;
    logic       SEL_N;
    logic       ACK_N;
    logic       RST_N;
    logic       BSY_N;
    logic       REQ_N;
    logic       MSG_N;
    logic       CD_N;
    logic       IO_N;

    modport master (
        input  DB_I, BSY_N, REQ_N, MSG_N, CD_N, IO_N,
        output DB_O, SEL_N, ACK_N, RST_N
    );

    modport slave (
        output DB_I, BSY_N, REQ_N, MSG_N, CD_N, IO_N,
        input  DB_O, SEL_N, ACK_N, RST_N
    );
endinterface

// File: rtl/scsi_initiator.sv
// Host-side SCSI initiator: selection, bus reset and per-byte REQ/ACK handshakes,
// bridging the bus to valid/ready byte streams for the CPU-side register block.
module scsi_initiator #(
    parameter int unsigned SEL_TIMEOUT_CYC = 10740,
    parameter int unsigned RST_HOLD_CYC    = 1074,
    parameter int unsigned DATA_SETUP_CYC  = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    scsi_initiator_if.master bus,
    input  logic             SEL_REQ,
    input  logic             BUS_RST_REQ,
    input  logic [7:0]       TX_DATA,
    input  logic             TX_VALID,
    output logic             TX_READY,
    output logic [7:0]       RX_DATA,
    output logic             RX_VALID,
    input  logic             RX_READY,
    output logic [2:0]       PHASE,
    output logic             CONNECTED,
    output logic             SEL_TIMEOUT,
    output logic             BUS_FREE,
    output logic [15:0]      BYTE_CNT
);
    typedef enum logic [3:0] {
        IDLE, BUS_RST, SEL_WAIT, SEL_REL, WAIT_REQ,
        OUT_SETUP, ACK_ASSERT, ACK_RELEASE, IN_HOLD
    } state_t;

    // SEL_N falls in cycle 1 and the timer is 0 there, so the registered timeout
    // decision is taken at timer = N-2 to land the pulse in cycle SEL_TIMEOUT_CYC.
    localparam logic [15:0] SEL_LAST   = 16'(SEL_TIMEOUT_CYC - 2);
    localparam logic [15:0] RST_LAST   = 16'(RST_HOLD_CYC - 1);
    localparam logic [15:0] SETUP_LAST = 16'(DATA_SETUP_CYC - 1);

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt, timer_inc;
    logic [7:0]  db_o_q, db_o_nxt, rx_data_q, rx_data_nxt;
    logic        sel_n_q, sel_n_nxt, ack_n_q, ack_n_nxt, rst_n_q, rst_n_nxt;
    logic        tx_ready_q, tx_ready_nxt, rx_valid_q, rx_valid_nxt;
    logic        connected_q, connected_nxt, sel_timeout_nxt, bus_free_nxt;
    logic        sel_timeout_q, bus_free_q;
    logic [15:0] byte_cnt_q, byte_cnt_nxt;
    logic [2:0]  phase_q;
    logic        in_connection;

    assign timer_inc     = (timer == 16'hFFFF) ? timer : timer + 16'd1;
    assign in_connection = state inside {WAIT_REQ, OUT_SETUP, ACK_ASSERT, ACK_RELEASE, IN_HOLD};

    always_comb begin
        // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
        state_nxt       = state;
        timer_nxt       = timer;
        db_o_nxt        = db_o_q;
        rx_data_nxt     = rx_data_q;
        sel_n_nxt       = sel_n_q;
        ack_n_nxt       = ack_n_q;
        rst_n_nxt       = rst_n_q;
        tx_ready_nxt    = tx_ready_q;
        rx_valid_nxt    = rx_valid_q;
        connected_nxt   = connected_q;
        byte_cnt_nxt    = byte_cnt_q;
        sel_timeout_nxt = 1'b0;
        bus_free_nxt    = 1'b0;

        if (BUS_RST_REQ) begin
            state_nxt     = BUS_RST;
            timer_nxt     = '0;
            rst_n_nxt     = 1'b0;
            sel_n_nxt     = 1'b1;
            ack_n_nxt     = 1'b1;
            tx_ready_nxt  = 1'b0;
            rx_valid_nxt  = 1'b0;
            connected_nxt = 1'b0;
        end else if (in_connection && bus.BSY_N) begin
            state_nxt     = IDLE;
            sel_n_nxt     = 1'b1;
            ack_n_nxt     = 1'b1;
            tx_ready_nxt  = 1'b0;
            rx_valid_nxt  = 1'b0;
            connected_nxt = 1'b0;
            bus_free_nxt  = 1'b1;
        end else begin
            case (state)
                IDLE: if (SEL_REQ && bus.BSY_N) begin
                    state_nxt = SEL_WAIT;
                    sel_n_nxt = 1'b0;
                    timer_nxt = '0;
                end
                BUS_RST: if (timer == RST_LAST) begin
                    state_nxt = IDLE;
                    rst_n_nxt = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
                SEL_WAIT: if (!bus.BSY_N) begin
                    state_nxt     = SEL_REL;
                    sel_n_nxt     = 1'b1;
                    connected_nxt = 1'b1;
                    byte_cnt_nxt  = '0;
                end else if (timer == SEL_LAST) begin
                    state_nxt       = IDLE;
                    sel_n_nxt       = 1'b1;
                    sel_timeout_nxt = 1'b1;
                end else begin
                    timer_nxt = timer_inc;
                end
                SEL_REL: state_nxt = WAIT_REQ;
                WAIT_REQ: if (TX_VALID && tx_ready_q) begin
                    state_nxt    = OUT_SETUP;
                    db_o_nxt     = TX_DATA;
                    tx_ready_nxt = 1'b0;
                    timer_nxt    = '0;
                end else if (!bus.REQ_N && !bus.IO_N) begin
                    state_nxt    = IN_HOLD;
                    rx_data_nxt  = bus.DB_I;
                    rx_valid_nxt = 1'b1;
                    tx_ready_nxt = 1'b0;
                end else begin
                    tx_ready_nxt = !bus.REQ_N && bus.IO_N;
                end
                OUT_SETUP: if (timer == SETUP_LAST) begin
                    state_nxt = ACK_ASSERT;
                    ack_n_nxt = 1'b0;
                end else begin
                    timer_nxt = timer_inc;
                end
                IN_HOLD: if (RX_READY) begin
                    state_nxt    = ACK_ASSERT;
                    rx_valid_nxt = 1'b0;
                    ack_n_nxt    = 1'b0;
                end
                ACK_ASSERT: if (bus.REQ_N) begin
                    state_nxt    = ACK_RELEASE;
                    ack_n_nxt    = 1'b1;
                    byte_cnt_nxt = byte_cnt_q + 16'd1;
                end
                ACK_RELEASE: state_nxt = WAIT_REQ;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state         <= IDLE;
            timer         <= '0;
            db_o_q        <= '0;
            rx_data_q     <= '0;
            sel_n_q       <= 1'b1;
            ack_n_q       <= 1'b1;
            rst_n_q       <= 1'b1;
            tx_ready_q    <= 1'b0;
            rx_valid_q    <= 1'b0;
            connected_q   <= 1'b0;
            sel_timeout_q <= 1'b0;
            bus_free_q    <= 1'b0;
            byte_cnt_q    <= '0;
            phase_q       <= '0;
        end else begin
            // NOTE: non-blocking so every register updates from pre-edge values.
            state         <= state_nxt;
            timer         <= timer_nxt;
            db_o_q        <= db_o_nxt;
            rx_data_q     <= rx_data_nxt;
            sel_n_q       <= sel_n_nxt;
            ack_n_q       <= ack_n_nxt;
            rst_n_q       <= rst_n_nxt;
            tx_ready_q    <= tx_ready_nxt;
            rx_valid_q    <= rx_valid_nxt;
            connected_q   <= connected_nxt;
            sel_timeout_q <= sel_timeout_nxt;
            bus_free_q    <= bus_free_nxt;
            byte_cnt_q    <= byte_cnt_nxt;
            phase_q       <= {~bus.MSG_N, ~bus.CD_N, ~bus.IO_N};
        end
    end

    assign bus.DB_O    = db_o_q;
    assign bus.SEL_N   = sel_n_q;
    assign bus.ACK_N   = ack_n_q;
    assign bus.RST_N   = rst_n_q;
    assign TX_READY    = tx_ready_q;
    assign RX_DATA     = rx_data_q;
    assign RX_VALID    = rx_valid_q;
    assign PHASE       = phase_q;
    assign CONNECTED   = connected_q;
    assign SEL_TIMEOUT = sel_timeout_q;
    assign BUS_FREE    = bus_free_q;
    assign BYTE_CNT    = byte_cnt_q;
endmodule
